// File: rtl/dpi_pi_filter_if.sv
// Loop-filter control/data bundle between the CDR front end and the PI filter.
// The master side drives the phase error and controls; the slave side returns the PI code.
interface dpi_pi_filter_if #(
    parameter int unsigned Nadc = 8,
    parameter int unsigned Npi  = 8,
    parameter int unsigned Nint = 16
);
    logic                   en;
    logic                   in_vld;
    logic signed [Nadc-1:0] in;
    logic                   sel_ext;
    logic [Npi-1:0]         pi_ctl_ext;
    logic [3:0]             kp_shift;
    logic [3:0]             ki_shift;
    logic [2:0]             dec_log2;
    logic                   int_clr;
    logic [Npi-1:0]         out;
    logic                   out_vld;
    logic signed [Nint-1:0] int_state;
    logic                   int_sat;

    modport master (
        output en, in_vld, in, sel_ext, pi_ctl_ext, kp_shift, ki_shift, dec_log2, int_clr,
        input  out, out_vld, int_state, int_sat
    );

    modport slave (
        input  en, in_vld, in, sel_ext, pi_ctl_ext, kp_shift, ki_shift, dec_log2, int_clr,
        output out, out_vld, int_state, int_sat
    );
endinterface

// File: rtl/dpi_pi_filter.sv
// Second-order (P + I) CDR loop filter: decimates the phase error, integrates frequency,
// accumulates a wrapping phase and emits the PI code with a bumpless external override.
module dpi_pi_filter #(
    parameter int unsigned Nlf  = 14,
    parameter int unsigned Nadc = 8,
    parameter int unsigned Npi  = 8,
    parameter int unsigned Nint = 16,
    parameter int unsigned Nif  = 8,
    parameter int unsigned Ndec = 4
) (
    input logic            clk,
    input logic            rst,
    dpi_pi_filter_if.slave bus
);
    localparam int unsigned Nlff = Nlf - Npi;
    localparam int unsigned Nacc = Nadc + Ndec;
    localparam int unsigned Nd   = $clog2(Ndec + 1);

    localparam logic signed [Nint-1:0] INT_MAX = {1'b0, {(Nint-1){1'b1}}};
    localparam logic signed [Nint-1:0] INT_MIN = {1'b1, {(Nint-1){1'b0}}};

    logic signed [Nacc-1:0] acc;
    logic [Ndec-1:0]        cnt;
    logic [Nd-1:0]          d_lat;
    logic signed [Nadc-1:0] err_reg;
    logic                   upd;
    logic                   upd_d;
    logic signed [Nint-1:0] int_reg;
    logic                   int_sat_q;
    logic [Nlf-1:0]         ph_reg;
    logic [Npi-1:0]         out_q;
    logic                   out_vld_q;

    logic                   accept;
    logic                   last;
    logic [Nd-1:0]          d_req;
    logic [Nd-1:0]          d_cur;
    logic signed [Nacc-1:0] acc_sum;
    logic signed [Nadc-1:0] err_next;
    logic signed [Nadc-1:0] err_ki;
    logic signed [Nadc-1:0] err_kp;
    logic signed [Nint:0]   int_sum;
    logic signed [Nint-1:0] int_next;
    logic                   int_sat_next;
    logic [Nlf-1:0]         ph_next;

    assign accept = bus.en && bus.in_vld && !bus.sel_ext;

    // Requested decimation clamped to Ndec; only sampled on the first sample of a window.
    always_comb begin
        d_req = Nd'(bus.dec_log2);
        if (32'(bus.dec_log2) > Ndec) begin
            d_req = Nd'(Ndec);
        end
    end

    assign d_cur    = (cnt == '0) ? d_req : d_lat;
    assign last     = (32'(cnt) == ((32'(1) << d_cur) - 32'(1)));
    assign acc_sum  = acc + $signed({{Ndec{bus.in[Nadc-1]}}, bus.in});
    assign err_next = Nadc'(acc_sum >>> d_cur);

    // Integral path with saturation detected from the extra sign bit.
    assign err_ki  = err_reg >>> bus.ki_shift;
    assign int_sum = $signed({int_reg[Nint-1], int_reg})
                   + $signed({{(Nint+1-Nadc){err_ki[Nadc-1]}}, err_ki});

    always_comb begin
        int_next = int_sum[Nint-1:0];
        if (int_sum[Nint] != int_sum[Nint-1]) begin
            int_next = int_sum[Nint] ? INT_MIN : INT_MAX;
        end
    end

    assign int_sat_next = (int_next == INT_MAX) || (int_next == INT_MIN);

    // Phase wraps modulo 2^Nlf; the integral term uses the pre-update int_reg.
    assign err_kp  = err_reg >>> bus.kp_shift;
    assign ph_next = ph_reg
                   + {{(Nlf-Nadc){err_kp[Nadc-1]}}, err_kp}
                   + Nlf'(int_reg >>> Nif);

    // Decimator: window accumulation and per-window error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            d_lat   <= '0;
            err_reg <= '0;
            upd     <= 1'b0;
        end else if (bus.en) begin
            if (bus.sel_ext) begin
                acc     <= '0;
                cnt     <= '0;
                err_reg <= '0;
                upd     <= 1'b0;
            end else begin
                upd <= accept && last;
                if (accept) begin
                    if (cnt == '0) begin
                        d_lat <= d_req;
                    end
                    if (last) begin
                        err_reg <= err_next;
                        acc     <= '0;
                        cnt     <= '0;
                    end else begin
                        acc <= acc_sum;
                        cnt <= cnt + Ndec'(1);
                    end
                end
            end
        end
    end

    // Integral state; a clear wins over a same-cycle update and the override holds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_reg   <= '0;
            int_sat_q <= 1'b0;
        end else if (bus.en) begin
            if (bus.int_clr) begin
                int_reg   <= '0;
                int_sat_q <= 1'b0;
            end else if (upd && !bus.sel_ext) begin
                int_reg   <= int_next;
                int_sat_q <= int_sat_next;
            end
        end
    end

    // Phase accumulator and registered code; the override reloads phase for bumpless release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_reg    <= '0;
            upd_d     <= 1'b0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else if (!bus.en) begin
            out_vld_q <= 1'b0;
        end else if (bus.sel_ext) begin
            ph_reg    <= {bus.pi_ctl_ext, {Nlff{1'b0}}};
            upd_d     <= 1'b0;
            out_q     <= bus.pi_ctl_ext;
            out_vld_q <= 1'b0;
        end else begin
            if (upd) begin
                ph_reg <= ph_next;
            end
            upd_d     <= upd;
            out_q     <= ph_reg[Nlf-1:Nlff];
            out_vld_q <= upd_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_vld   = out_vld_q;
    assign bus.int_state = int_reg;
    assign bus.int_sat   = int_sat_q;
endmodule

// File: tb/tb_dpi_pi_filter.sv
// Directed bench for dpi_pi_filter: an integer reference model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_dpi_pi_filter;
    logic clk;
    logic rst;

    dpi_pi_filter_if bus ();

    dpi_pi_filter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec  = 0;
    int n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int fdiv(input int a, input int sh);
        int d;
        int q;
        d = 1 << sh;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // Reference model: integer phase/frequency arithmetic, one step per clock.
    int m_n = 0, m_sum = 0, m_d = 0, m_err = 0, m_int = 0, m_ph = 0, m_out = 0;
    bit m_upd = 0, m_upd_d = 0, m_vld = 0;
    int o_err, o_int, o_ph, v;
    bit o_upd, o_upd_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_sum = 0; m_d = 0; m_err = 0; m_int = 0; m_ph = 0; m_out = 0;
            m_upd = 0; m_upd_d = 0; m_vld = 0;
        end else if (!bus.en) begin
            m_vld = 0;
        end else begin
            o_err = m_err; o_int = m_int; o_ph = m_ph; o_upd = m_upd; o_upd_d = m_upd_d;
            if (bus.sel_ext) begin
                m_n = 0; m_sum = 0; m_err = 0; m_upd = 0; m_upd_d = 0;
                m_ph = int'(bus.pi_ctl_ext) * 64;
                m_out = int'(bus.pi_ctl_ext);
                m_vld = 0;
            end else begin
                m_upd = 0;
                if (bus.in_vld) begin
                    if (m_n == 0) m_d = (int'(bus.dec_log2) > 4) ? 4 : int'(bus.dec_log2);
                    m_sum = m_sum + int'(bus.in);
                    m_n = m_n + 1;
                    if (m_n == (1 << m_d)) begin
                        m_err = fdiv(m_sum, m_d);
                        m_upd = 1;
                        m_n = 0;
                        m_sum = 0;
                    end
                end
                if (o_upd) begin
                    v = o_ph + fdiv(o_err, int'(bus.kp_shift)) + fdiv(o_int, 8);
                    m_ph = ((v % 16384) + 16384) % 16384;
                end
                m_upd_d = o_upd;
                m_out = o_ph / 64;
                m_vld = o_upd_d;
            end
            if (bus.int_clr) begin
                m_int = 0;
            end else if (o_upd && !bus.sel_ext) begin
                v = o_int + fdiv(o_err, int'(bus.ki_shift));
                m_int = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
            end
        end
    end

    always @(negedge clk) begin
        check("out", int'(bus.out), m_out);
        check("out_vld", int'(bus.out_vld), int'(m_vld));
        check("int_state", int'(bus.int_state), m_int);
        check("int_sat", int'(bus.int_sat), (m_int == 32767 || m_int == -32768) ? 1 : 0);
    end

    initial begin
        int dec_vals[4] = '{3, 5, -1, 1};

        rst = 1'b0;
        bus.en = 1'b0; bus.in_vld = 1'b0; bus.in = '0; bus.sel_ext = 1'b0;
        bus.pi_ctl_ext = '0; bus.kp_shift = '0; bus.ki_shift = '0; bus.dec_log2 = '0;
        bus.int_clr = 1'b0;
        #1 rst = 1'b1;
        cycles(3);

        // Random activity, then asynchronous reset between edges.
        rst = 1'b0;
        bus.en = 1'b1; bus.in_vld = 1'b1; bus.ki_shift = 4'd2;
        for (int i = 0; i < 20; i++) begin
            bus.in = 8'($urandom);
            cycles(1);
        end
        #2 rst = 1'b1;
        #1;
        check("rst_out", int'(bus.out), 0);
        check("rst_out_vld", int'(bus.out_vld), 0);
        check("rst_int_state", int'(bus.int_state), 0);
        check("rst_int_sat", int'(bus.int_sat), 0);
        cycles(3);
        check("rst_hold_out", int'(bus.out), 0);
        check("rst_hold_int", int'(bus.int_state), 0);

        // Proportional only: +4 per sample.
        bus.in = 8'sd4; bus.in_vld = 1'b1; bus.dec_log2 = 3'd0; bus.kp_shift = 4'd0;
        bus.ki_shift = 4'd0; bus.int_clr = 1'b1;
        rst = 1'b0;
        cycles(17);
        check("prop_out_0", int'(bus.out), 0);
        cycles(1);
        check("prop_out_1", int'(bus.out), 1);
        cycles(16);
        check("prop_out_2", int'(bus.out), 2);
        check("prop_vld", int'(bus.out_vld), 1);

        // Wrap from forced code 255.
        bus.in_vld = 1'b0; bus.sel_ext = 1'b1; bus.pi_ctl_ext = 8'd255;
        cycles(2);
        check("wrap_forced", int'(bus.out), 255);
        bus.sel_ext = 1'b0; bus.in_vld = 1'b1; bus.in = 8'sd64;
        cycles(1);
        bus.in_vld = 1'b0;
        cycles(2);
        check("wrap_out", int'(bus.out), 0);
        check("wrap_vld", int'(bus.out_vld), 1);

        // Integral saturation.
        bus.int_clr = 1'b0; bus.in = 8'sd127; bus.in_vld = 1'b1;
        cycles(259);
        check("sat_pre_int", int'(bus.int_state), 32766);
        check("sat_pre_flag", int'(bus.int_sat), 0);
        cycles(1);
        check("sat_int", int'(bus.int_state), 32767);
        check("sat_flag", int'(bus.int_sat), 1);
        cycles(40);
        bus.in = -8'sd128;
        cycles(1);
        bus.in_vld = 1'b0;
        cycles(1);
        check("desat_int", int'(bus.int_state), 32639);
        check("desat_flag", int'(bus.int_sat), 0);

        // Decimation by 4 with idle gaps.
        bus.dec_log2 = 3'd2; bus.int_clr = 1'b1;
        cycles(1);
        bus.int_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_vld = 1'b1; bus.in = 8'(dec_vals[i]);
            cycles(1);
            bus.in_vld = 1'b0;
            if (i < 3) cycles(2);
        end
        cycles(1);
        check("dec_vld_early", int'(bus.out_vld), 0);
        cycles(1);
        check("dec_vld", int'(bus.out_vld), 1);
        check("dec_int", int'(bus.int_state), 2);
        cycles(1);
        check("dec_vld_late", int'(bus.out_vld), 0);

        // Decimation request above the maximum clamps to 16 samples.
        bus.dec_log2 = 3'd7; bus.in = -8'sd1; bus.in_vld = 1'b1;
        cycles(15);
        check("clamp_partial", int'(bus.int_state), 2);
        cycles(1);
        bus.in_vld = 1'b0;
        cycles(2);
        check("clamp_int", int'(bus.int_state), 1);

        // Load int_reg = 1024, then override with a pending update discarded.
        bus.dec_log2 = 3'd0; bus.int_clr = 1'b1;
        cycles(1);
        bus.int_clr = 1'b0; bus.in_vld = 1'b1; bus.in = 8'sd127;
        cycles(8);
        bus.in = 8'sd8;
        cycles(1);
        bus.in_vld = 1'b0;
        cycles(2);
        check("load_int", int'(bus.int_state), 1024);
        bus.in_vld = 1'b1; bus.in = 8'sd100;
        cycles(1);
        bus.sel_ext = 1'b1; bus.pi_ctl_ext = 8'h5A; bus.in = 8'sd50;
        cycles(10);
        check("ext_int", int'(bus.int_state), 1024);
        check("ext_out", int'(bus.out), 90);
        bus.sel_ext = 1'b0; bus.in_vld = 1'b0;
        cycles(2);
        check("bumpless_out", int'(bus.out), 90);

        // Freeze with a pending update, applied when en returns.
        bus.in_vld = 1'b1; bus.in = 8'sd64;
        cycles(1);
        bus.en = 1'b0;
        cycles(5);
        check("freeze_int", int'(bus.int_state), 1024);
        check("freeze_vld", int'(bus.out_vld), 0);
        bus.en = 1'b1; bus.in_vld = 1'b0;
        cycles(1);
        check("thaw_int", int'(bus.int_state), 1088);
        cycles(1);
        check("thaw_vld", int'(bus.out_vld), 1);
        check("thaw_out", int'(bus.out), 91);

        cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
